sparse_weight_packer: RTL

Producer-side companion to the sparse dot-product row: accepts dense weight groups of `n` signed values, one lane per beat, and compresses each group to `nnz` packed values plus an `n`-bit position mask. This is exactly the `weights_flat` / `w_index` format the row's lanes consume. After `M` lanes it emits one full row word through a valid/ready handshake. A one-row collect buffer plus an output register let input streaming continue while the previous row waits.

---
 rtl/sparse_weight_packer_if.sv | 27 ++
 rtl/sparse_weight_packer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sparse_weight_packer_if.sv
// Dense-group input stream and packed-row output stream of sparse_weight_packer.
// master drives groups and takes rows; slave is the packer.
interface sparse_weight_packer_if #(
    parameter int bw  = 4,
    parameter int nnz = 2,
    parameter int n   = 4,
    parameter int M   = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [n*bw-1:0]       in_weights;
    logic                  out_valid;
    logic                  out_ready;
    logic [M*nnz*bw-1:0]   weights_flat;
    logic [M*n-1:0]        w_index;
    logic [M-1:0]          violation;

    modport master (
        output in_valid, in_weights, out_ready,
        input  in_ready, out_valid, weights_flat, w_index, violation
    );

    modport slave (
        input  in_valid, in_weights, out_ready,
        output in_ready, out_valid, weights_flat, w_index, violation
    );
endinterface

// File: rtl/sparse_weight_packer.sv
// Packs dense n-wide weight groups into nnz values + n-bit mask per lane, M lanes per row.
// Latency: out_valid the edge after the last lane is accepted (output register free). SPW_MAGNITUDE_PRUNE_EN keeps largest |w|.
// Backpressure: one collect row buffers behind a stalled output; in_ready drops only when both are occupied.
module sparse_weight_packer #(
    parameter int bw  = 4,
    parameter int nnz = 2,
    parameter int n   = 4,
    parameter int M   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    sparse_weight_packer_if.slave  bus,
    output logic                   err_sticky
);
    localparam int LW = nnz * bw;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {COLLECT, FULL} state_t;
    state_t state;

    logic signed [bw-1:0] w [n];
    logic [n-1:0]         nz;
    logic [n-1:0]         pk_mask;
    logic [LW-1:0]        pk_vals;
    logic                 pk_viol;
`ifdef SPW_MAGNITUDE_PRUNE_EN
    logic [bw:0]          mag [n];
`endif

    always_comb begin
        int nz_cnt;
        int slot;
`ifdef SPW_MAGNITUDE_PRUNE_EN
        int rank;
`else
        int kept;
`endif
        nz_cnt  = 0;
        slot    = 0;
        pk_mask = '0;
        pk_vals = '0;
        for (int k = 0; k < n; k++) begin
            w[k]  = bus.in_weights[k*bw +: bw];
            nz[k] = (bus.in_weights[k*bw +: bw] != '0);
            if (nz[k]) nz_cnt = nz_cnt + 1;
        end
`ifdef SPW_MAGNITUDE_PRUNE_EN
        // Rank every element by magnitude (ties to lower index); zeros rank last,
        // so the same rule also pads under-dense groups with the lowest-index zeros.
        for (int k = 0; k < n; k++) begin
            mag[k] = w[k][bw-1] ? (~{w[k][bw-1], w[k]} + 1'b1) : {1'b0, w[k]};
        end
        for (int k = 0; k < n; k++) begin
            rank = 0;
            for (int j = 0; j < n; j++) begin
                if (j != k && (mag[j] > mag[k] || (mag[j] == mag[k] && j < k)))
                    rank = rank + 1;
            end
            pk_mask[k] = (rank < nnz);
        end
`else
        kept = 0;
        for (int k = 0; k < n; k++) begin
            if (nz[k] && kept < nnz) begin
                pk_mask[k] = 1'b1;
                kept = kept + 1;
            end
        end
        for (int k = 0; k < n; k++) begin
            if (!pk_mask[k] && kept < nnz) begin
                pk_mask[k] = 1'b1;
                kept = kept + 1;
            end
        end
`endif
        for (int k = 0; k < n; k++) begin
            if (pk_mask[k]) begin
                if (slot < nnz) pk_vals[slot*bw +: bw] = w[k];
                slot = slot + 1;
            end
        end
        pk_viol = (nz_cnt > nnz);
    end

    logic [CW-1:0]   lane_cnt;
    logic [M*LW-1:0] col_vals, row_vals, out_vals;
    logic [M*n-1:0]  col_mask, row_mask, out_mask;
    logic [M-1:0]    col_viol, row_viol, out_viol;
    logic            in_rdy, out_vld;
    logic            accept, last_lane, out_free;

    assign accept    = bus.in_valid && in_rdy;
    assign last_lane = (lane_cnt == CW'(M - 1));
    assign out_free  = !out_vld || bus.out_ready;

    // Completed row for the bypass load: collected lanes plus the incoming last lane.
    always_comb begin
        row_vals = col_vals;
        row_mask = col_mask;
        row_viol = col_viol;
        row_vals[(M-1)*LW +: LW] = pk_vals;
        row_mask[(M-1)*n +: n]   = pk_mask;
        row_viol[M-1]            = pk_viol;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= COLLECT;
            in_rdy     <= 1'b1;
            out_vld    <= 1'b0;
            lane_cnt   <= '0;
            err_sticky <= 1'b0;
            col_vals   <= '0;
            col_mask   <= '0;
            col_viol   <= '0;
            out_vals   <= '0;
            out_mask   <= '0;
            out_viol   <= '0;
        end else begin
            if (accept && pk_viol) err_sticky <= 1'b1;
            case (state)
                COLLECT: begin
                    if (bus.out_ready) out_vld <= 1'b0;
                    if (accept) begin
                        col_vals[lane_cnt*LW +: LW] <= pk_vals;
                        col_mask[lane_cnt*n +: n]   <= pk_mask;
                        col_viol[lane_cnt]          <= pk_viol;
                        if (last_lane) begin
                            lane_cnt <= '0;
                            if (out_free) begin
                                out_vals <= row_vals;
                                out_mask <= row_mask;
                                out_viol <= row_viol;
                                out_vld  <= 1'b1;
                            end else begin
                                state  <= FULL;
                                in_rdy <= 1'b0;
                            end
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_vld && bus.out_ready) begin
                        out_vals <= col_vals;
                        out_mask <= col_mask;
                        out_viol <= col_viol;
                        state    <= COLLECT;
                        in_rdy   <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready     = in_rdy;
    assign bus.out_valid    = out_vld;
    assign bus.weights_flat = out_vals;
    assign bus.w_index      = out_mask;
    assign bus.violation    = out_viol;
endmodule
